logical_driver: RTL
===================

# logical_driver

Command-side driver and checker for the registered logical unit. Accepts operation commands over a valid/ready interface, drives the logical unit's A/B/instruction inputs, waits its one-clock registered latency, captures the result, and returns it over a valid/ready response interface. Each result is compared against an internal model of the eight logical operations, and mismatches are flagged. Sits between the ALU command source and the logical unit.

## Interface
- N, 4, operand and result width
- M, 4, opcode field width is M-1 (eight operations)
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command
- cmd_data  in  2N+M-1  {op[M-2:0], A[N-1:0], B[N-1:0]}; op in the MSBs, B in the LSBs (N=4, M=4: op [10:8], A [7:4], B [3:0])
- lu_a  out  N  operand A to the logical unit (registered)
- lu_b  out  N  operand B to the logical unit (registered)
- lu_instr  out  M-1  instruction to the logical unit (registered)
- lu_out  in  N  logical unit result
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_data  out  N  captured result
- rsp_err  out  1  captured result differs from the model
- err_flag  out  1  sticky; set on any mismatch
- op_count  out  8  completed responses, wrapping
- err_count  out  8  mismatches, saturating at 255

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register op/A/B into lu_instr/lu_a/lu_b and go to ISSUE.
- ISSUE:
  - One cycle. lu_* outputs are stable, and the logical unit samples them on the closing edge.
  - Go to CAPTURE.
- CAPTURE:
  - One cycle. lu_out is valid.
  - On the closing edge, register rsp_data<=lu_out and rsp_err<=(lu_out!=expected).
  - If there is a mismatch, set err_flag and increment err_count (saturate at 255).
  - Go to RESP.
- RESP:
  - rsp_valid=1.
  - On rsp_ready, increment op_count (255 wraps to 0) and go to IDLE.
- Model expected value, computed from the registered lu_a/lu_b/lu_instr:
  - op 0: A&B
  - op 1: A|B
  - op 2: A^B
  - op 3: ~(A|B)
  - op 4: ~(A&B)
  - op 5: ~(A^B)
  - op 6: unsigned A>B
  - op 7: A==B
  - Ops 6 and 7 produce 1 or 0, zero-extended to N bits. All other results are N bits wide.
- cmd_ready is 1 only in IDLE. No new command is accepted in RESP, even when rsp_ready is high.
- lu_a/lu_b/lu_instr hold their values until the next accepted command.
- rsp_data/rsp_err hold until the next CAPTURE.
- A command presented outside IDLE is not consumed; the source must hold it.
- err_flag and err_count clear only on reset.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - lu_a, lu_b, lu_instr, rsp_data, rsp_err, rsp_valid, err_flag, op_count and err_count all go to 0.
  - cmd_ready reads 1. Handshakes while rst_n is low are ignored.
- Reset mid-operation (ISSUE, CAPTURE or RESP): the in-flight command is discarded and no response is produced.
- Accept at edge E0:
  - lu_* are valid after E0.
  - The logical unit registers at E1.
  - Capture occurs at E2.
  - rsp_valid is high after E2.
- Minimum command spacing is 4 cycles when rsp_ready is held high.
- Under backpressure, rsp_valid, rsp_data and rsp_err remain stable until the handshake.
- The logical unit has no reset. lu_out is never sampled except in CAPTURE.

## Test plan
- Reset: assert rst_n low mid-cycle -> all outputs listed above are 0 immediately, and cmd_ready=1.
- Accept op=0, A=0xC, B=0xA at edge E0 with rsp_ready=1 -> rsp_valid rises after E2, rsp_data=0x8, rsp_err=0, op_count=1.
- Compare ops:
  - op=6, A=5, B=3 -> 0x1
  - op=6, A=3, B=4 -> 0x0
  - op=7, A=3, B=3 -> 0x1
  - op=3, A=0x0, B=0x0 -> 0xF
  - All with rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid=1, rsp_data constant, cmd_ready=0 while cmd_valid=1. Raise rsp_ready -> IDLE, then the pending command is accepted.
- Error injection: bench forces lu_out=0xF for op=0, A=0, B=0 -> rsp_err=1, err_flag=1, err_count=1. The next correct op gives rsp_err=0 while err_flag stays 1.
- Reset asserted during CAPTURE -> no rsp_valid. After 256 completed ops from reset, op_count=0.

Source files
------------

// File: rtl/logical_driver.sv
// logical_driver: command-side driver and checker for a registered logical unit.
// Issues {op, A, B} to the unit, captures its one-cycle-late result, compares it
// against an internal model of the eight operations and returns it over valid/ready.
module logical_driver #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2*N+M-2:0]   cmd_data,
  output logic [N-1:0]       lu_a,
  output logic [N-1:0]       lu_b,
  output logic [M-2:0]       lu_instr,
  input  logic [N-1:0]       lu_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_data,
  output logic               rsp_err,
  output logic               err_flag,
  output logic [7:0]         op_count,
  output logic [7:0]         err_count
);

  localparam int unsigned OW = M - 1;
  localparam int unsigned CW = 2 * N + OW;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  state_e         state_q, state_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [N-1:0]   lu_a_q, lu_a_d;
  logic [N-1:0]   lu_b_q, lu_b_d;
  logic [OW-1:0]  lu_instr_q, lu_instr_d;
  logic [N-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           err_flag_q, err_flag_d;
  logic [7:0]     op_count_q, op_count_d;
  logic [7:0]     err_count_q, err_count_d;
  logic [N-1:0]   expected_c;
  logic           mismatch_c;

  // Reference result for the operation currently held on the lu_* outputs
  always_comb begin
    expected_c = '0;
    case (lu_instr_q)
      OW'(0):  expected_c = lu_a_q & lu_b_q;
      OW'(1):  expected_c = lu_a_q | lu_b_q;
      OW'(2):  expected_c = lu_a_q ^ lu_b_q;
      OW'(3):  expected_c = ~(lu_a_q | lu_b_q);
      OW'(4):  expected_c = ~(lu_a_q & lu_b_q);
      OW'(5):  expected_c = ~(lu_a_q ^ lu_b_q);
      OW'(6):  expected_c = N'(lu_a_q > lu_b_q);
      default: expected_c = N'(lu_a_q == lu_b_q);
    endcase
    mismatch_c = (lu_out != expected_c);
  end

  // Next-state and next-value logic for every register
  always_comb begin
    state_d     = state_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    lu_instr_d  = lu_instr_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_flag_d  = err_flag_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          lu_instr_d = cmd_data[CW-1 -: OW];
          lu_a_d     = cmd_data[2*N-1 -: N];
          lu_b_d     = cmd_data[N-1:0];
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        rsp_data_d = lu_out;
        rsp_err_d  = mismatch_c;
        if (mismatch_c) begin
          err_flag_d = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      lu_instr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_flag_q  <= 1'b0;
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_instr_q  <= lu_instr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_flag_q  <= err_flag_d;
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_instr  = lu_instr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign err_flag  = err_flag_q;
  assign op_count  = op_count_q;
  assign err_count = err_count_q;

endmodule
